// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronised, masked, fixed-priority external interrupt controller with claim/complete handshake.
module irq_ctrl #(
    parameter int          N_SRC       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_MASK   = 32'hFFFF_FFFF,
    localparam int         ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             irq_ack_i,
    output logic             meip_o,
    output logic             claim_valid_o,
    output logic [ID_W-1:0]  claim_id_o,
    input  logic             reg_we_i,
    input  logic [1:0]       reg_addr_i,
    input  logic [31:0]      reg_wdata_i,
    output logic [31:0]      reg_rdata_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [N_SRC-1:0] EM = EDGE_MASK[N_SRC-1:0];

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] sync_d [SYNC_STAGES];
    logic [N_SRC-1:0] s, sd_q, en_q, en_d, pend_q, pend_d, act, clr;
    state_t           state_q, state_d;
    logic             valid_q, valid_d, fire;
    logic [ID_W-1:0]  id_q, id_d, win;
    logic             wr_en, wr_pend, wr_comp;
    logic             unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign act          = pend_q & en_q;
    assign wr_en        = reg_we_i && reg_addr_i == 2'd0;
    assign wr_pend      = reg_we_i && reg_addr_i == 2'd1;
    assign wr_comp      = reg_we_i && reg_addr_i == 2'd3;
    assign unused_wdata = ^reg_wdata_i;

    always_comb begin
        sync_d[0] = irq_src_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) if (act[i]) win = ID_W'(i);
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: if (act != '0) state_d = REQ;
            REQ: begin
                if (act == '0) state_d = IDLE;
                else if (irq_ack_i) begin
                    state_d = SERVICE;
                    valid_d = 1'b1;
                    id_d    = win;
                    fire    = 1'b1;
                end
            end
            SERVICE: begin
                if (wr_comp && reg_wdata_i[ID_W-1:0] == id_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge bits: set beats clear; level bits simply track the synchronised input.
    always_comb begin
        clr    = (wr_pend ? reg_wdata_i[N_SRC-1:0] : '0) | (fire ? N_SRC'(1) << win : '0);
        pend_d = (EM & ((pend_q & ~clr) | (s & ~sd_q))) | (~EM & s);
        en_d   = wr_en ? reg_wdata_i[N_SRC-1:0] : en_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sd_q    <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            sd_q    <= s;
            en_q    <= en_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign meip_o        = state_q == REQ;
    assign claim_valid_o = valid_q;
    assign claim_id_o    = id_q;
    assign reg_rdata_o   = reg_addr_i == 2'd0 ? 32'(en_q) :
                           reg_addr_i == 2'd1 ? 32'(pend_q) :
                           reg_addr_i == 2'd2 ? {valid_q, 31'(id_q)} : '0;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table plus hand sequences for irq_ctrl (src 7 configured as level).
module tb_irq_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] irq_src_i;
    logic        irq_ack_i;
    logic        meip_o, claim_valid_o;
    logic [3:0]  claim_id_o;
    logic        reg_we_i;
    logic [1:0]  reg_addr_i;
    logic [31:0] reg_wdata_i, reg_rdata_o;
    logic [31:0] r;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [15:0] src;
        logic        ack;
        logic [1:0]  raddr;
        logic        meip;
        logic        valid;
        logic [3:0]  id;
        logic [31:0] rdata;
    } vec_t;

    vec_t vec [19];

    irq_ctrl #(.N_SRC(16), .SYNC_STAGES(2), .EDGE_MASK(32'hFFFF_FF7F)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .irq_src_i(irq_src_i), .irq_ack_i(irq_ack_i),
        .meip_o(meip_o), .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o),
        .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_rdata_o(reg_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d, input logic ack);
        reg_we_i = we;
        reg_addr_i = a;
        reg_wdata_i = d;
        irq_ack_i = ack;
        @(posedge clk_i);
        #1;
        reg_we_i = 1'b0;
        irq_ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_we_i = 1'b0;
        reg_addr_i = a;
        #1;
        d = reg_rdata_o;
    endtask

    task automatic rst_pulse();
        irq_src_i = '0;
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        //            we addr wdata         src      ack raddr meip val id  rdata
        vec[0]  = '{1'b1, 2'd0, 32'h10,   16'h0,    1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 32'h10};
        vec[1]  = '{1'b0, 2'd0, 32'h0,    16'h10,   1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 32'h0};
        vec[2]  = '{1'b0, 2'd0, 32'h0,    16'h10,   1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 32'h0};
        vec[3]  = '{1'b0, 2'd0, 32'h0,    16'h10,   1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 32'h10};
        vec[4]  = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd1, 1'b1, 1'b0, 4'd0, 32'h10};
        vec[5]  = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b1, 2'd2, 1'b0, 1'b1, 4'd4, 32'h8000_0004};
        vec[6]  = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd1, 1'b0, 1'b1, 4'd4, 32'h0};
        vec[7]  = '{1'b1, 2'd3, 32'h4,    16'h0,    1'b0, 2'd2, 1'b0, 1'b0, 4'd4, 32'h4};
        vec[8]  = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd3, 1'b0, 1'b0, 4'd4, 32'h0};
        vec[9]  = '{1'b1, 2'd0, 32'hFFFF, 16'h0,    1'b0, 2'd0, 1'b0, 1'b0, 4'd4, 32'hFFFF};
        vec[10] = '{1'b0, 2'd0, 32'h0,    16'h0204, 1'b0, 2'd1, 1'b0, 1'b0, 4'd4, 32'h0};
        vec[11] = '{1'b0, 2'd0, 32'h0,    16'h0204, 1'b0, 2'd1, 1'b0, 1'b0, 4'd4, 32'h0};
        vec[12] = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd1, 1'b0, 1'b0, 4'd4, 32'h0204};
        vec[13] = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd1, 1'b1, 1'b0, 4'd4, 32'h0204};
        vec[14] = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b1, 2'd1, 1'b0, 1'b1, 4'd2, 32'h0200};
        vec[15] = '{1'b1, 2'd3, 32'h2,    16'h0,    1'b0, 2'd2, 1'b0, 1'b0, 4'd2, 32'h2};
        vec[16] = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b0, 2'd1, 1'b1, 1'b0, 4'd2, 32'h0200};
        vec[17] = '{1'b0, 2'd0, 32'h0,    16'h0,    1'b1, 2'd2, 1'b0, 1'b1, 4'd9, 32'h8000_0009};
        vec[18] = '{1'b1, 2'd3, 32'h9,    16'h0,    1'b0, 2'd1, 1'b0, 1'b0, 4'd9, 32'h0};

        reset_i = 1'b1;
        irq_src_i = '0;
        irq_ack_i = 1'b0;
        reg_we_i = 1'b0;
        reg_addr_i = 2'd0;
        reg_wdata_i = '0;
        #12;
        reset_i = 1'b0;
        chk("reset_meip", 32'(meip_o), 32'h0);
        chk("reset_valid", 32'(claim_valid_o), 32'h0);
        chk("reset_id", 32'(claim_id_o), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            chk($sformatf("reset_reg%0d", a), r, 32'h0);
        end
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 19; i++) begin
            irq_src_i = vec[i].src;
            step(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].ack);
            chk($sformatf("v%0d_meip", i), 32'(meip_o), 32'(vec[i].meip));
            chk($sformatf("v%0d_valid", i), 32'(claim_valid_o), 32'(vec[i].valid));
            chk($sformatf("v%0d_id", i), 32'(claim_id_o), 32'(vec[i].id));
            rd(vec[i].raddr, r);
            chk($sformatf("v%0d_rdata", i), r, vec[i].rdata);
        end

        // reset while servicing src 3
        rst_pulse();
        irq_src_i = 16'h8;
        step(1'b1, 2'd0, 32'h8, 1'b0);
        idle(3);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        chk("svc3_valid", 32'(claim_valid_o), 32'h1);
        chk("svc3_id", 32'(claim_id_o), 32'h3);
        irq_src_i = '0;
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_meip", 32'(meip_o), 32'h0);
        chk("arst_valid", 32'(claim_valid_o), 32'h0);
        chk("arst_id", 32'(claim_id_o), 32'h0);
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), r);
            chk($sformatf("arst_reg%0d", a), r, 32'h0);
        end
        reset_i = 1'b0;
        idle(6);
        chk("post_rst_meip", 32'(meip_o), 32'h0);
        rd(2'd1, r);
        chk("post_rst_pend", r, 32'h0);
        irq_src_i = 16'h8;
        step(1'b1, 2'd0, 32'h8, 1'b0);
        idle(3);
        chk("post_rst_new_edge_meip", 32'(meip_o), 32'h1);

        // masking and withdrawal on src 5
        rst_pulse();
        irq_src_i = 16'h20;
        idle(3);
        irq_src_i = '0;
        idle(2);
        rd(2'd1, r);
        chk("mask_pend", r, 32'h20);
        chk("mask_meip", 32'(meip_o), 32'h0);
        step(1'b1, 2'd0, 32'h20, 1'b0);
        chk("en_write_edge_meip", 32'(meip_o), 32'h0);
        idle(1);
        chk("enabled_meip", 32'(meip_o), 32'h1);
        step(1'b1, 2'd0, 32'h0, 1'b0);
        chk("disable_edge_meip", 32'(meip_o), 32'h1);
        idle(1);
        chk("withdrawn_meip", 32'(meip_o), 32'h0);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        chk("late_ack_valid", 32'(claim_valid_o), 32'h0);
        rd(2'd2, r);
        chk("late_ack_claim", r, 32'h0);
        step(1'b1, 2'd1, 32'h20, 1'b0);
        rd(2'd1, r);
        chk("w1c_edge_pend", r, 32'h0);

        // level source 7
        rst_pulse();
        irq_src_i = 16'h80;
        step(1'b1, 2'd0, 32'h80, 1'b0);
        idle(3);
        chk("lvl_meip", 32'(meip_o), 32'h1);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        chk("lvl_valid", 32'(claim_valid_o), 32'h1);
        chk("lvl_id", 32'(claim_id_o), 32'h7);
        rd(2'd1, r);
        chk("lvl_pend_after_claim", r, 32'h80);
        step(1'b1, 2'd3, 32'h7, 1'b0);
        chk("lvl_complete_valid", 32'(claim_valid_o), 32'h0);
        idle(1);
        chk("lvl_reassert_meip", 32'(meip_o), 32'h1);
        step(1'b1, 2'd1, 32'h80, 1'b0);
        rd(2'd1, r);
        chk("lvl_w1c_ignored", r, 32'h80);
        irq_src_i = '0;
        idle(2);
        rd(2'd1, r);
        chk("lvl_fall_2edges", r, 32'h80);
        idle(1);
        rd(2'd1, r);
        chk("lvl_fall_3edges", r, 32'h0);

        // set/clear collision on src 0, then wrong complete
        rst_pulse();
        irq_src_i = 16'h1;
        step(1'b1, 2'd0, 32'h1, 1'b0);
        idle(1);
        step(1'b1, 2'd1, 32'h1, 1'b0);
        rd(2'd1, r);
        chk("collide_pend", r, 32'h1);
        idle(1);
        chk("collide_meip", 32'(meip_o), 32'h1);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        chk("src0_id", 32'(claim_id_o), 32'h0);
        rd(2'd1, r);
        chk("src0_claim_clears", r, 32'h0);
        step(1'b1, 2'd3, 32'h5, 1'b0);
        chk("wrong_complete_valid", 32'(claim_valid_o), 32'h1);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        chk("service_ack_ignored", 32'(claim_valid_o), 32'h1);
        step(1'b1, 2'd3, 32'h0, 1'b0);
        chk("right_complete_valid", 32'(claim_valid_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
